rnn_cell_seq: RTL and testbench

//  Parametrised recurrent neuron: y = act(sum_i w[i]*x[i] + u*h + b), with h <= y after each step.

---
 rtl/rnn_cell_seq.sv | 158 +++++++++++++++
 tb/tb_rnn_cell_seq.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/rnn_cell_seq.sv
// Recurrent neuron y = act(sum w[i]*x[i] + u*h + b) with a single time-shared multiplier.
// Define RNN_CELL_RELU_EN to use a ReLU activation; otherwise the neuron is linear.
module rnn_cell_seq #(
    parameter int unsigned N_IN   = 8,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned FRAC_W = 16,
    localparam int unsigned SEL_W = $clog2(2 * N_IN + 2),
    localparam int unsigned ACC_W = 2 * DATA_W + $clog2(N_IN + 2)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [SEL_W-1:0]         wr_sel,
    input  logic signed [DATA_W-1:0] wr_data,
    input  logic                     start,
    input  logic                     h_clear,
    output logic                     busy,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_data
);
    localparam int unsigned IDX_W = $clog2(N_IN + 1);

    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W - DATA_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W - DATA_W + 1){1'b1}}, {(DATA_W - 1){1'b0}}};
    localparam logic signed [DATA_W-1:0] Y_MAX = {1'b0, {(DATA_W - 1){1'b1}}};
    localparam logic signed [DATA_W-1:0] Y_MIN = {1'b1, {(DATA_W - 1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StMac, StFin, StOut} state_e;

    state_e state_q, state_d;

    logic signed [DATA_W-1:0] x_q [N_IN];
    logic signed [DATA_W-1:0] w_q [N_IN];
    logic signed [DATA_W-1:0] u_q, b_q, h_q, h_d;
    logic signed [DATA_W-1:0] out_data_q, out_data_d;
    logic                     out_valid_q, out_valid_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [IDX_W-1:0]         idx_q, idx_d;

    logic signed [DATA_W-1:0]   mul_a, mul_b, b_eff, y;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext, acc_init, shifted, act_v;
    logic                       wr_ok;

    assign wr_ok = wr_en && (state_q == StIdle);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_IN; i++) begin
                x_q[i] <= '0;
                w_q[i] <= '0;
            end
            u_q <= '0;
            b_q <= '0;
        end else if (wr_ok) begin
            for (int i = 0; i < N_IN; i++) begin
                if (wr_sel == SEL_W'(i))        x_q[i] <= wr_data;
                if (wr_sel == SEL_W'(N_IN + i)) w_q[i] <= wr_data;
            end
            if (wr_sel == SEL_W'(2 * N_IN))     u_q <= wr_data;
            if (wr_sel == SEL_W'(2 * N_IN + 1)) b_q <= wr_data;
        end
    end

    // Recurrent term shares the multiplier on the final MAC cycle (idx == N_IN).
    always_comb begin
        mul_a = u_q;
        mul_b = h_q;
        for (int i = 0; i < N_IN; i++) begin
            if (idx_q == IDX_W'(i)) begin
                mul_a = w_q[i];
                mul_b = x_q[i];
            end
        end
    end

    assign prod     = mul_a * mul_b;
    assign prod_ext = {{(ACC_W - 2 * DATA_W){prod[2*DATA_W-1]}}, prod};

    // Forward a bias write landing on the same edge as start.
    assign b_eff    = (wr_ok && wr_sel == SEL_W'(2 * N_IN + 1)) ? wr_data : b_q;
    assign acc_init = {{(ACC_W - DATA_W){b_eff[DATA_W-1]}}, b_eff} <<< FRAC_W;
    assign shifted  = acc_q >>> FRAC_W;

    always_comb begin
`ifdef RNN_CELL_RELU_EN
        act_v = shifted[ACC_W-1] ? '0 : shifted;
`else
        act_v = shifted;
`endif
        if (act_v > SAT_MAX)      y = Y_MAX;
        else if (act_v < SAT_MIN) y = Y_MIN;
        else                      y = act_v[DATA_W-1:0];
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        idx_d       = idx_q;
        h_d         = h_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        unique case (state_q)
            StIdle: begin
                if (h_clear) h_d = '0;
                if (start) begin
                    state_d = StMac;
                    acc_d   = acc_init;
                    idx_d   = '0;
                end
            end
            StMac: begin
                acc_d = acc_q + prod_ext;
                if (idx_q == IDX_W'(N_IN)) state_d = StFin;
                else                       idx_d   = idx_q + IDX_W'(1);
            end
            StFin: begin
                out_data_d  = y;
                h_d         = y;
                out_valid_d = 1'b1;
                state_d     = StOut;
            end
            StOut: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            idx_q       <= '0;
            h_q         <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            h_q         <= h_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign busy      = (state_q != StIdle);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_rnn_cell_seq.sv
// Directed bench for rnn_cell_seq (N_IN=8, Q16.16); expectations follow RNN_CELL_RELU_EN.
module tb_rnn_cell_seq;
    localparam int N_IN = 8;
    localparam logic [31:0] ONE      = 32'h0001_0000;
    localparam logic [31:0] HALF     = 32'h0000_8000;
    localparam logic [31:0] NEG_HALF = 32'hFFFF_8000;
    localparam logic [31:0] MAXP     = 32'h7FFF_FFFF;
`ifdef RNN_CELL_RELU_EN
    localparam logic [31:0] EXP_SAT_NEG = 32'h0000_0000;
    localparam logic [31:0] EXP_NEG4    = 32'h0000_0000;
`else
    localparam logic [31:0] EXP_SAT_NEG = 32'h8000_0000;
    localparam logic [31:0] EXP_NEG4    = 32'hFFFC_0000;
`endif

    logic        clk = 1'b0, rst = 1'b1;
    logic        wr_en = 1'b0, start = 1'b0, h_clear = 1'b0, out_ready = 1'b0;
    logic [4:0]  wr_sel = '0;
    logic [31:0] wr_data = '0;
    logic        busy, out_valid;
    logic [31:0] out_data;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rnn_cell_seq #(.N_IN(N_IN), .DATA_W(32), .FRAC_W(16)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .start(start), .h_clear(h_clear), .busy(busy), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wr(input int sel, input logic [31:0] d);
        wr_en = 1'b1; wr_sel = 5'(sel); wr_data = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic set_w(input logic [31:0] w);
        for (int i = 0; i < N_IN; i++) wr(N_IN + i, w);
    endtask

    task automatic load(input logic [31:0] x, input logic [31:0] w,
                        input logic [31:0] u, input logic [31:0] b);
        for (int i = 0; i < N_IN; i++) wr(i, x);
        set_w(w);
        wr(2 * N_IN, u);
        wr(2 * N_IN + 1, b);
    endtask

    task automatic run_step(input string tag, input logic [31:0] exp, input bit clr, input bit ack);
        int cyc = 0;
        start = 1'b1; h_clear = clr;
        @(posedge clk); #1;
        start = 1'b0; h_clear = 1'b0; wr_en = 1'b0;
        while (!out_valid && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, "_lat"}, 32'(cyc), 32'(N_IN + 2));
        check({tag, "_data"}, out_data, exp);
        if (ack) begin
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            check({tag, "_idle"}, {31'b0, busy}, 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_valid", {31'b0, out_valid}, 32'd0);
        check("rst_data", out_data, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        load(ONE, HALF, 32'd0, 32'd0);
        run_step("basic", 32'h0004_0000, 1'b0, 1'b1);

        wr(2 * N_IN, ONE);
        h_clear = 1'b1; @(posedge clk); #1; h_clear = 1'b0;
        run_step("rec1", 32'h0004_0000, 1'b0, 1'b1);
        run_step("rec2", 32'h0008_0000, 1'b0, 1'b1);
        run_step("rec_clr", 32'h0004_0000, 1'b1, 1'b1);

        load(MAXP, MAXP, ONE, MAXP);
        run_step("sat_pos", MAXP, 1'b0, 1'b1);
        set_w(32'h8000_0001);
        run_step("sat_neg", EXP_SAT_NEG, 1'b0, 1'b1);

        load(ONE, NEG_HALF, 32'd0, 32'd0);
        run_step("sign", EXP_NEG4, 1'b0, 1'b1);
        set_w(32'd0);
        wr(2 * N_IN, ONE);
        run_step("h_state", EXP_NEG4, 1'b0, 1'b1);

        // Bias write, h_clear and start all on one edge: 4.0 + 1.0 + 0.
        set_w(HALF);
        wr_en = 1'b1; wr_sel = 5'(2 * N_IN + 1); wr_data = ONE;
        run_step("same_edge", 32'h0005_0000, 1'b1, 1'b1);

        wr(2 * N_IN, 32'd0);
        wr(2 * N_IN + 1, 32'd0);
        run_step("bp", 32'h0004_0000, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            if (k == 1) begin
                start = 1'b1; wr_en = 1'b1; wr_sel = 5'(2 * N_IN + 1); wr_data = 32'h0010_0000;
            end
            @(posedge clk); #1;
            start = 1'b0; wr_en = 1'b0;
            check("bp_valid", {31'b0, out_valid}, 32'd1);
            check("bp_data", out_data, 32'h0004_0000);
            check("bp_busy", {31'b0, busy}, 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_rel_busy", {31'b0, busy}, 32'd0);
        check("bp_rel_valid", {31'b0, out_valid}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("bp_no_queue", {31'b0, busy}, 32'd0);
        wr(2 * N_IN + 2, 32'h1234_5678);
        wr(31, 32'h1234_5678);
        run_step("bp_regs", 32'h0004_0000, 1'b0, 1'b1);

        // Reset four edges into a step.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("mid_busy", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", {31'b0, busy}, 32'd0);
        check("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        check("mid_rst_data", out_data, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        run_step("post_rst", 32'd0, 1'b0, 1'b1);
        load(ONE, HALF, 32'd0, 32'd0);
        run_step("reload", 32'h0004_0000, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
